// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM responder and its controller: default
// timing parameters, command encodings and the responder state type.
package psram_pkg;

  localparam int PSRAM_BURST_BEATS  = 32;
  localparam int PSRAM_TCMD         = 42;
  localparam int PSRAM_READ_LATENCY = 8;
  localparam int PSRAM_MEM_AW       = 10;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } psram_cmd_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/psram_responder_if.sv
// Command/data bus between a PSRAM controller (master) and the responder (slave).
interface psram_responder_if;
  logic [20:0] psram_addr;
  logic        psram_cmd;
  logic        psram_cmd_en;
  logic [63:0] psram_write_data;
  logic [63:0] psram_read_data;
  logic        psram_read_data_valid;
  logic        busy;
  logic        cmd_collision;

  modport master (
    output psram_addr, psram_cmd, psram_cmd_en, psram_write_data,
    input  psram_read_data, psram_read_data_valid, busy, cmd_collision
  );

  modport slave (
    input  psram_addr, psram_cmd, psram_cmd_en, psram_write_data,
    output psram_read_data, psram_read_data_valid, busy, cmd_collision
  );
endinterface

// File: rtl/psram_model_ram.sv
// Backing store: simple dual-port RAM, one write port and one registered
// read port. Contents start at zero and are never touched by reset.
module psram_model_ram #(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [0:(1<<AW)-1] = '{default: {DW{1'b0}}};
  logic [DW-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/psram_responder.sv
// Cycle-accurate PSRAM burst responder: accepts one command per TCMD-cycle
// window, stores write bursts and replays read bursts after READ_LATENCY.
module psram_responder
  import psram_pkg::*;
#(
  parameter int BURST_BEATS  = PSRAM_BURST_BEATS,
  parameter int TCMD         = PSRAM_TCMD,
  parameter int READ_LATENCY = PSRAM_READ_LATENCY,
  parameter int MEM_AW       = PSRAM_MEM_AW
) (
  input logic              sys_clk,
  input logic              sys_rst,
  psram_responder_if.slave bus
);
  // The read pipeline (RAM register + output register) needs two cycles,
  // and the counter is 8 bits wide.
  if ((READ_LATENCY + BURST_BEATS > TCMD) || (READ_LATENCY < 3) ||
      (TCMD > 255) || (MEM_AW < 1) || (MEM_AW > 20)) begin : g_param_err
    $error("psram_responder: illegal parameter combination");
  end

  localparam logic [7:0] TCMD_C     = 8'(TCMD);
  localparam logic [7:0] BEATS_C    = 8'(BURST_BEATS);
  localparam logic [7:0] RD_START_C = 8'(READ_LATENCY - 2);
  localparam logic [7:0] RD_END_C   = 8'(READ_LATENCY - 2 + BURST_BEATS);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] base_q, base_d;
  psram_cmd_e        cmd_q, cmd_d;
  logic              coll_q, coll_d;
  logic              accept_s;
  logic              wr_en_s, rd_en_s;
  logic [MEM_AW-1:0] wr_addr_s, rd_addr_s;
  logic [63:0]       ram_rdata_s;
  logic              rd_v1_q, rd_valid_q;
  logic [63:0]       rd_data_q;

  // Command window FSM: acceptance, counter, collision detection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    cmd_d    = cmd_q;
    coll_d   = coll_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.psram_cmd_en) accept_s = 1'b1;
        else                  accept_s = 1'b0;
      end
      ST_ACTIVE: begin
        if (cnt_q == TCMD_C) begin
          // Window closes this edge; a new strobe here is a legal command.
          accept_s = bus.psram_cmd_en;
          state_d  = ST_IDLE;
          cnt_d    = 8'd0;
        end else begin
          accept_s = 1'b0;
          cnt_d    = cnt_q + 8'd1;
          if (bus.psram_cmd_en) coll_d = 1'b1;
          else                  coll_d = coll_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (accept_s) begin
      state_d = ST_ACTIVE;
      cnt_d   = 8'd1;
      base_d  = MEM_AW'(bus.psram_addr >> 5'd1);
      cmd_d   = psram_cmd_e'(bus.psram_cmd);
    end else begin
      cmd_d = cmd_q;
    end
  end

  // FSM and command registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      base_q  <= {MEM_AW{1'b0}};
      cmd_q   <= CMD_READ;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      cmd_q   <= cmd_d;
      coll_q  <= coll_d;
    end
  end

  // Write port: beat 0 in the strobe cycle, beat k while cnt == k
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = base_q + MEM_AW'(cnt_q);
    if (accept_s && (psram_cmd_e'(bus.psram_cmd) == CMD_WRITE)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = base_d;
    end else if ((state_q == ST_ACTIVE) && (cmd_q == CMD_WRITE) && (cnt_q < BEATS_C)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Read address issue: two cycles ahead of the beat appearing on the bus
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = base_q + MEM_AW'(cnt_q - RD_START_C);
    if ((state_q == ST_ACTIVE) && (cmd_q == CMD_READ) &&
        (cnt_q >= RD_START_C) && (cnt_q < RD_END_C)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  psram_model_ram #(.AW(MEM_AW), .DW(64)) u_ram (
    .clk_i   (sys_clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_addr_s),
    .wdata_i (bus.psram_write_data),
    .re_i    (rd_en_s),
    .raddr_i (rd_addr_s),
    .rdata_o (ram_rdata_s)
  );

  // Read output pipeline; data forced to zero outside valid beats
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_v1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 64'd0;
    end else begin
      rd_v1_q    <= rd_en_s;
      rd_valid_q <= rd_v1_q;
      rd_data_q  <= rd_v1_q ? ram_rdata_s : 64'd0;
    end
  end

  assign bus.psram_read_data       = rd_data_q;
  assign bus.psram_read_data_valid = rd_valid_q;
  assign bus.busy                  = (state_q == ST_ACTIVE);
  assign bus.cmd_collision         = coll_q;
endmodule
